line_buf_writer: RTL

LINE_BUF_WRITER -- requirements
Module: line_buf_writer

---
 rtl/line_buf_writer.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/line_buf_writer.sv
// Double-banked 640-column VGA line buffer writer: tracks the displayed row, swaps banks on
// row changes and requests the next line from a pixel source (two columns per accepted beat).
module line_buf_writer #(
   parameter int BLANK_CHANGES = 46
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [8:0]             line_number,
   input  logic                   pix_valid,
   input  logic [11:0]            pix_rgb,
   output logic                   pix_ready,
   output logic                   line_req,
   output logic [8:0]             line_req_num,
   output logic [639:0][2:0][3:0] lbuffer,
   output logic                   underrun
);

   localparam int CNT_W = $clog2(BLANK_CHANGES + 1);

   typedef enum logic [1:0] {SYNC, ACTIVE, VBLANK} sync_t;
   typedef enum logic [1:0] {IDLE, REQ, FILL, FULL} fill_t;

   sync_t                   r_sync;
   fill_t                   r_fill;
   logic [CNT_W-1:0]        r_blank_cnt;
   logic                    r_sel;
   logic [8:0]              r_prev_line;
   logic [639:0][2:0][3:0]  r_bank0;
   logic [639:0][2:0][3:0]  r_bank1;
   logic [8:0]              r_pix_cnt;
   logic                    r_pix_ready;
   logic                    r_line_req;
   logic [8:0]              r_line_req_num;
   logic                    r_underrun;

   logic                    w_change;
   logic                    w_swap;
   logic                    w_req;
   logic                    w_to_vblank;
   logic [8:0]              w_req_num;
   logic [CNT_W-1:0]        w_blank_next;
   logic                    w_beat;
   logic [9:0]              w_col0;
   logic [9:0]              w_col1;
   logic [2:0][3:0]         w_pix;

   // Row-change decode is combinational so the swap is visible in the cycle the row changes.
   always_comb begin
      w_change     = reset && (line_number != r_prev_line);
      w_swap       = 1'b0;
      w_req        = 1'b0;
      w_to_vblank  = 1'b0;
      w_req_num    = 9'd0;
      w_blank_next = r_blank_cnt + CNT_W'(1);
      if (w_change) begin
         case (r_sync)
            SYNC: begin
               if (line_number == 9'd480) begin
                  w_to_vblank = 1'b1;
                  w_req       = 1'b1;
               end
            end
            VBLANK: begin
               if (w_blank_next == CNT_W'(BLANK_CHANGES)) begin
                  w_swap    = 1'b1;
                  w_req     = 1'b1;
                  w_req_num = 9'd1;
               end
            end
            ACTIVE: begin
               if (line_number >= 9'd480) begin
                  w_to_vblank = 1'b1;
                  w_req       = 1'b1;
               end else if (line_number == 9'd479) begin
                  w_swap = 1'b1;
               end else if (line_number != 9'd0) begin
                  w_swap    = 1'b1;
                  w_req     = 1'b1;
                  w_req_num = line_number + 9'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign w_beat  = pix_valid && r_pix_ready && !w_req && !w_swap;
   assign w_col0  = {r_pix_cnt, 1'b0};
   assign w_col1  = w_col0 + 10'd1;
   assign w_pix   = {pix_rgb[3:0], pix_rgb[7:4], pix_rgb[11:8]};

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_sync      <= SYNC;
         r_blank_cnt <= '0;
         r_sel       <= 1'b0;
         r_prev_line <= line_number;
      end else begin
         r_prev_line <= line_number;
         if (w_swap)
            r_sel <= ~r_sel;
         if (w_to_vblank) begin
            r_sync      <= VBLANK;
            r_blank_cnt <= CNT_W'(1);
         end else if (r_sync == VBLANK && w_change) begin
            r_blank_cnt <= w_blank_next;
            if (w_swap)
               r_sync <= ACTIVE;
         end
      end
   end

   // A request overrides everything and restarts the fill; a bare swap parks the filler.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_fill         <= IDLE;
         r_pix_cnt      <= '0;
         r_pix_ready    <= 1'b0;
         r_line_req     <= 1'b0;
         r_line_req_num <= '0;
         r_underrun     <= 1'b0;
         r_bank0        <= '0;
         r_bank1        <= '0;
      end else begin
         r_line_req <= w_req;
         if (w_swap && r_fill != FULL)
            r_underrun <= 1'b1;
         if (w_req) begin
            r_fill         <= REQ;
            r_line_req_num <= w_req_num;
            r_pix_cnt      <= '0;
            r_pix_ready    <= 1'b0;
         end else if (w_swap) begin
            r_fill      <= IDLE;
            r_pix_ready <= 1'b0;
         end else begin
            case (r_fill)
               REQ: begin
                  r_fill      <= FILL;
                  r_pix_ready <= 1'b1;
               end
               FILL: begin
                  if (w_beat) begin
                     if (r_sel) begin
                        r_bank0[w_col0] <= w_pix;
                        r_bank0[w_col1] <= w_pix;
                     end else begin
                        r_bank1[w_col0] <= w_pix;
                        r_bank1[w_col1] <= w_pix;
                     end
                     r_pix_cnt <= r_pix_cnt + 9'd1;
                     if (r_pix_cnt == 9'd319) begin
                        r_fill      <= FULL;
                        r_pix_ready <= 1'b0;
                     end
                  end
               end
               default: r_pix_ready <= 1'b0;
            endcase
         end
      end
   end

   assign lbuffer      = (r_sel ^ w_swap) ? r_bank1 : r_bank0;
   assign pix_ready    = r_pix_ready;
   assign line_req     = r_line_req;
   assign line_req_num = r_line_req_num;
   assign underrun     = r_underrun;

endmodule
